// File: rtl/nibble_program_loader.sv
// nibble_program_loader
// Program-memory front end for the NibbleBuddy core. A byte stream on a
// valid/ready handshake fills a DEPTH x INSTR_W instruction memory. Any unused
// tail is zero-filled with NOPs. The core is held in reset until the image is
// complete. Instructions are then served combinationally from program_counter.
//
// Optional feature: define LOADER_CHECKSUM_EN to add a checksum byte after the
// last program byte. This adds the CHECK state, the ERROR state and the running
// sum register. Without it, load_error is tied low.
module nibble_program_loader #(
    parameter int DEPTH   = 32,
    parameter int INSTR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [INSTR_W-1:0]       load_byte,
    input  logic                     load_last,
    output logic                     load_ready,
    input  logic                     reload,
    input  logic [$clog2(DEPTH)-1:0] program_counter,
    output logic [INSTR_W-1:0]       instruction,
    output logic                     cpu_reset,
    output logic                     loaded,
    output logic                     load_error
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LOAD, CHECK, FILL, RUN, ERROR} state_t;
`else
    typedef enum logic [1:0] {LOAD, FILL, RUN} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        wr_ptr_next;
    logic                 mem_we;
    logic [INSTR_W-1:0]   mem_wdata;
    logic [INSTR_W-1:0]   mem [DEPTH];

`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0]   sum;
    logic [INSTR_W-1:0]   sum_next;
    logic [INSTR_W-1:0]   sum_check;
`endif

    // State, write pointer and running sum; reset returns to an empty LOAD.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values produced by the combinational block below.
        if (reset) begin
            state  <= LOAD;
            wr_ptr <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum    <= '0;
`endif
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr_next;
`ifdef LOADER_CHECKSUM_EN
            sum    <= sum_next;
`endif
        end
    end

    // Instruction memory write port: program bytes during LOAD, NOPs during FILL.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset; FILL overwrites
        // every address not covered by the program, so stale contents never
        // reach the core.
        if (mem_we && !reset) begin
            mem[wr_ptr] <= mem_wdata;
        end
    end

    // Next-state logic, write control and outputs decoded from the registered state.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement leaves one unassigned (no latches).
        state_next  = state;
        wr_ptr_next = wr_ptr;
        mem_we      = 1'b0;
        mem_wdata   = load_byte;
        load_ready  = 1'b0;
        cpu_reset   = 1'b1;
        loaded      = 1'b0;
        load_error  = 1'b0;
        instruction = '0;
`ifdef LOADER_CHECKSUM_EN
        sum_next    = sum;
        sum_check   = sum + load_byte;
`endif

        case (state)
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_next    = sum + load_byte;
`endif
                    // A write to the top address ends the load even without load_last.
                    if (load_last || (wr_ptr == LAST_ADDR)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = (wr_ptr == LAST_ADDR) ? RUN : FILL;
`endif
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (sum_check == '0) begin
                        // wr_ptr has wrapped to 0 only after a full-depth program.
                        state_next = (wr_ptr == '0) ? RUN : FILL;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end

            ERROR: begin
                load_error = 1'b1;
            end
`endif

            FILL: begin
                mem_we      = 1'b1;
                mem_wdata   = '0;
                wr_ptr_next = wr_ptr + 1'b1;
                if (wr_ptr == LAST_ADDR) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                cpu_reset   = 1'b0;
                loaded      = 1'b1;
                instruction = mem[program_counter];
                if (reload) begin
                    state_next  = LOAD;
                    wr_ptr_next = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_next    = '0;
`endif
                end
            end

            default: begin
                state_next  = LOAD;
                wr_ptr_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_program_loader.sv
// tb_nibble_program_loader
// Directed bench for nibble_program_loader. Inputs change on the falling edge
// and outputs are sampled on the falling edge, away from the active edge.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_nibble_program_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_byte;
    logic       load_last;
    logic       load_ready;
    logic       reload;
    logic [4:0] program_counter;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic       loaded;
    logic       load_error;

    int         vectors    = 0;
    int         miscompares = 0;
    int         cyc        = 0;
    logic [7:0] prog [32];

    nibble_program_loader #(.DEPTH(32), .INSTR_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_valid      (load_valid),
        .load_byte       (load_byte),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .reload          (reload),
        .program_counter (program_counter),
        .instruction     (instruction),
        .cpu_reset       (cpu_reset),
        .loaded          (loaded),
        .load_error      (load_error)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to measure load-to-RUN latency.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers (start and end on a falling edge) ----

    task automatic do_reset();
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; reload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard = 0;
        load_valid = 1'b1; load_byte = b; load_last = last;
        while (load_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            vectors++; miscompares++;
            $display("FAIL send_byte: load_ready stuck at %b, wanted 1", load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0; load_byte = 8'h00;
    endtask

    task automatic wait_run(input int mark, output int delta);
        int guard = 0;
        bit bad = 1'b0;
        while (loaded !== 1'b1 && load_error !== 1'b1 && guard < 200) begin
            if (cpu_reset !== 1'b1) bad = 1'b1;
            @(negedge clk);
            guard++;
        end
        delta = cyc - mark;
        vectors++;
        if (guard >= 200) begin
            miscompares++;
            $display("FAIL wait_run: no RUN/ERROR after %0d cycles, wanted <200", guard);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL cpu_reset_hold: got 0 before RUN, wanted 1");
        end
    endtask

    task automatic send_checksum(input int n);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + prog[i];
        send_byte(8'h00 - s, 1'b0);
`else
        if (n < 0) $display("negative length");
`endif
    endtask

    // Sends prog[0..n-1] (plus checksum when enabled) and waits for RUN.
    task automatic load_program(input int n, input logic use_last, output int delta);
        int mark;
        for (int i = 0; i < n; i++) send_byte(prog[i], use_last && (i == n - 1));
        mark = cyc;
        send_checksum(n);
        wait_run(mark, delta);
    endtask

    task automatic check_image(input int n, input string tag);
        logic [7:0] want;
        for (int a = 0; a < 32; a++) begin
            program_counter = 5'(a);
            #1;
            want = (a < n) ? prog[a] : 8'h00;
            vectors++;
            if (instruction !== want) begin
                miscompares++;
                $display("FAIL %s[%0d]: got %h want %h", tag, a, instruction, want);
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        do_reset();
        program_counter = 5'd0;
        #1;
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL rst_load_ready: got %b want 1", load_ready); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL rst_loaded: got %b want 0", loaded); end
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL rst_load_error: got %b want 0", load_error); end
        vectors++; if (instruction !== 8'h00) begin miscompares++; $display("FAIL rst_instruction: got %h want 00", instruction); end
        @(negedge clk);
    endtask

    task automatic test_short_program();
        int delta;
        logic [4:0] pcs   [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
        logic [7:0] wants [5] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        do_reset();
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        load_program(3, 1'b1, delta);
        vectors++; if (delta != 29 + CKS) begin miscompares++; $display("FAIL short_latency: got %0d edges want %0d", delta, 29 + CKS); end
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL short_loaded: got %b want 1", loaded); end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("FAIL short_cpu_reset: got %b want 0", cpu_reset); end
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL short_load_ready: got %b want 0", load_ready); end
        for (int i = 0; i < 5; i++) begin
            program_counter = pcs[i];
            #1;
            vectors++;
            if (instruction !== wants[i]) begin
                miscompares++;
                $display("FAIL short_fetch pc=%0d: got %h want %h", pcs[i], instruction, wants[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_full_program();
        int delta;
        int mark;
        do_reset();
        for (int i = 0; i < 32; i++) prog[i] = 8'(i);
        for (int i = 0; i < 32; i++) send_byte(prog[i], 1'b0);
        mark = cyc;
`ifdef LOADER_CHECKSUM_EN
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL full_check_ready: got %b want 1", load_ready); end
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL full_check_loaded: got %b want 0", loaded); end
`else
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_fall: got %b want 0", load_ready); end
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL full_loaded_now: got %b want 1", loaded); end
`endif
        send_checksum(32);
        wait_run(mark, delta);
        vectors++; if (delta != CKS) begin miscompares++; $display("FAIL full_latency: got %0d edges want %0d", delta, CKS); end
        program_counter = 5'd5;
        #1;
        vectors++; if (instruction !== 8'h05) begin miscompares++; $display("FAIL full_pc5: got %h want 05", instruction); end
        @(negedge clk);
        check_image(32, "full_image");
    endtask

    task automatic test_reset_midload();
        int delta;
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        program_counter = 5'd0;
        #1;
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", load_ready); end
        vectors++; if (instruction !== 8'h00) begin miscompares++; $display("FAIL midrst_instruction: got %h want 00", instruction); end
        @(negedge clk);
        prog[0] = 8'hAA;
        load_program(1, 1'b1, delta);
        vectors++; if (delta != 31 + CKS) begin miscompares++; $display("FAIL midrst_latency: got %0d edges want %0d", delta, 31 + CKS); end
        check_image(1, "midrst_image");
    endtask

    task automatic test_reload();
        int delta;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        program_counter = 5'd0;
        #1;
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL reload_loaded: got %b want 0", loaded); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reload_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reload_ready: got %b want 1", load_ready); end
        vectors++; if (instruction !== 8'h00) begin miscompares++; $display("FAIL reload_instruction: got %h want 00", instruction); end
        @(negedge clk);
        prog[0] = 8'h5C;
        load_program(1, 1'b1, delta);
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL reload_rerun: got %b want 1", loaded); end
        check_image(1, "reload_image");
        // reset and reload on the same edge: reset wins, same LOAD result
        reset = 1'b1; reload = 1'b1;
        @(negedge clk);
        reset = 1'b0; reload = 1'b0;
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL rst_reload_loaded: got %b want 0", loaded); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL rst_reload_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_random_valid();
        int   idx = 0;
        int   guard = 0;
        int   delta;
        int   mark;
        logic v;
        logic rdy;
        logic [7:0] seq [8] = '{8'h3C, 8'h7E, 8'h01, 8'hF0, 8'h55, 8'h9A, 8'h12, 8'hC4};
        do_reset();
        for (int i = 0; i < 8; i++) prog[i] = seq[i];
        while (idx < 8 && guard < 200) begin
            v          = 1'($urandom_range(0, 1));
            load_valid = v;
            load_byte  = v ? prog[idx] : 8'($urandom_range(0, 255));
            load_last  = v ? (idx == 7) : 1'($urandom_range(0, 1));
            rdy        = load_ready;
            @(negedge clk);
            if (v && rdy) idx++;
            guard++;
        end
        load_valid = 1'b0; load_last = 1'b0;
        vectors++; if (idx != 8) begin miscompares++; $display("FAIL rand_progress: got %0d bytes want 8", idx); end
        mark = cyc;
        send_checksum(8);
        wait_run(mark, delta);
        check_image(8, "rand_image");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int delta;
        int mark;
        do_reset();
        prog[0] = 8'h10; prog[1] = 8'h20;
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b1);
        mark = cyc;
        send_byte(8'hD0, 1'b0);
        wait_run(mark, delta);
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL cks_ok_loaded: got %b want 1", loaded); end
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL cks_ok_error: got %b want 0", load_error); end
        vectors++; if (delta != 31) begin miscompares++; $display("FAIL cks_ok_latency: got %0d want 31", delta); end
        check_image(2, "cks_image");

        do_reset();
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b1);
        mark = cyc;
        send_byte(8'hD1, 1'b0);
        wait_run(mark, delta);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
        program_counter = 5'd0;
        #1;
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL cks_bad_error: got %b want 1", load_error); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL cks_bad_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL cks_bad_loaded: got %b want 0", loaded); end
        vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL cks_bad_ready: got %b want 0", load_ready); end
        vectors++; if (instruction !== 8'h00) begin miscompares++; $display("FAIL cks_bad_instruction: got %h want 00", instruction); end
        @(negedge clk);
        do_reset();
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL cks_clear_error: got %b want 0", load_error); end
    endtask
`endif

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
        reload = 1'b0; program_counter = 5'd0;
        test_reset();
        test_short_program();
        test_full_program();
        test_reset_midload();
        test_reload();
        test_random_valid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nibble_program_loader.md
# nibble_program_loader

Program-memory front end for the NibbleBuddy processor. It accepts a program as a byte stream over a valid/ready handshake, stores it in a 32 x 8 instruction memory, and zero-fills any unused tail. It holds the processor in reset until the image is complete, then serves `instruction` combinationally from the processor's `program_counter`. It sits directly upstream of the processor core and drives its `reset` and `instruction` inputs.

## Interface
- `DEPTH`, 32, instruction memory words; equals 2^width of `program_counter`
- `INSTR_W`, 8, instruction width in bits
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`
- `load_valid`  input  1  `load_byte` is valid this cycle
- `load_byte`  input  8  program byte, or checksum byte when checksum is enabled
- `load_last`  input  1  qualifies `load_byte` as the final program byte
- `load_ready`  output  1  loader accepts a byte this cycle
- `reload`  input  1  single-cycle request to reload the program, honoured only in RUN
- `program_counter`  input  5  processor fetch address
- `instruction`  output  8  instruction word to the processor
- `cpu_reset`  output  1  drives the processor `reset`
- `loaded`  output  1  a valid image is present and the processor is running
- `load_error`  output  1  checksum mismatch detected

## Operation
- States: LOAD, CHECK, FILL, RUN, ERROR. Outputs are decoded from the registered state.
  - `load_ready` = 1 in LOAD and CHECK.
  - `cpu_reset` = 1 in every state except RUN.
  - `loaded` = 1 in RUN.
  - `load_error` = 1 in ERROR.
- Reset (any state, including mid-load):
  - state <= LOAD, `wr_ptr` <= 0, `sum` <= 0.
  - Outputs after the reset edge: `load_ready`=1, `cpu_reset`=1, `loaded`=0, `load_error`=0, `instruction`=8'h00.
  - Memory contents are not cleared.
- Transfer: occurs on an edge where `load_valid` and `load_ready` are both 1.
- LOAD, on each transfer:
  - mem[`wr_ptr`] <= `load_byte`; `wr_ptr` increments; `sum` <= `sum` + `load_byte` (mod 256).
  - Load ends on `load_last`, or on the transfer that writes address 31 (implicit last). Bytes after that are never accepted in LOAD.
  - At load end: go to CHECK if checksum is enabled; otherwise go to FILL if `wr_ptr`+1 < 32, else to RUN.
- CHECK: on one transfer, if (`sum` + `load_byte`) mod 256 == 0, go to FILL or RUN by the same rule as LOAD; otherwise go to ERROR. The checksum byte is not stored.
- FILL: writes 8'h00 (NOP) to mem[`wr_ptr`] each cycle and increments `wr_ptr`. The write to address 31 moves the state to RUN.
- RUN: `instruction` = mem[`program_counter`], combinational.
  - `reload`=1 moves the state to LOAD next edge with `wr_ptr` <= 0 and `sum` <= 0. `cpu_reset` rises in the same cycle that `loaded` falls.
- ERROR: held until `reset`. `reload` is ignored.
- `instruction` = 8'h00 in every state other than RUN.
- `load_valid` while `load_ready`=0 is ignored and never stalls anything. `load_last` is ignored outside LOAD.
- `wr_ptr` is 5 bits. It wraps to 0 when FILL or a 32-byte load completes.

## Timing
- Zero wait states: one byte per cycle when `load_valid` is held high.
- A program of N bytes (1 ≤ N ≤ 32) finishes on transfer edge k. RUN is entered:
  - at edge k + (32 − N) when N < 32;
  - at edge k when N = 32;
  - plus one edge for the CHECK transfer when checksum is enabled.
- `cpu_reset` falls and `loaded` rises in the first RUN cycle. The processor fetches address 0 on its first edge out of reset.
- Fetch latency is zero cycles: `program_counter` → `instruction` is purely combinational.
- `reset` and `reload` asserted on the same edge: `reset` wins, with an identical result.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CHECK state and the `sum` register are present.
  - Exactly one checksum byte follows the last program byte.
  - A mismatch latches ERROR.
- `LOADER_CHECKSUM_EN` undefined:
  - CHECK, ERROR and `sum` are removed.
  - `load_error` is tied to 0.
  - The transition at load end goes straight to FILL or RUN.

## Test plan
- Reset, then bytes 8'h11, 8'h22, 8'h33 with `load_last` on the third byte (no checksum) → 29 FILL cycles, then `loaded`=1 and `cpu_reset`=0. `program_counter`=0/1/2/3/31 → `instruction`=11/22/33/00/00.
- 32 back-to-back bytes 8'h00..8'h1F with no `load_last` → RUN on the 32nd transfer edge, FILL skipped, `program_counter`=5 → 8'h05. `load_ready` falls after the 32nd byte.
- Checksum enabled, bytes 8'h10, 8'h20 with `load_last`, then checksum 8'hD0 → RUN, `load_error`=0. Repeat with checksum 8'hD1 → ERROR, `cpu_reset` stays 1, `instruction`=8'h00, `reload` ignored.
- Assert `reset` after 2 of 5 bytes, then load 8'hAA with `load_last` → address 0 = 8'hAA and addresses 1..31 = 8'h00 (stale bytes are overwritten by FILL).
- In RUN, pulse `reload`, then load 8'h5C with `load_last` → `cpu_reset`=1 throughout the reload, and address 0 = 8'h5C after RUN is re-entered.
- Toggle `load_valid` randomly during LOAD → only qualified transfers are written, and the byte order is preserved.
